// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, operand forwarding select and stall/flush control.
// Ports: ID operands/dest in; stall, bubble, flush, fwd selects, stage_valid, event counters out.
module pipe_hazard_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter bit FWD_EN     = 1'b1,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              cpu_en,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wb_wen,
  input  logic [ADDR_W-1:0] id_wb_addr,
  input  logic              id_is_load,
  input  logic              id_branch_taken,
  output logic              stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  logic [DEPTH:1]    vld_q, vld_d;
  logic [DEPTH:1]    wen_q, wen_d;
  logic [DEPTH:1]    ld_q, ld_d;
  logic [ADDR_W-1:0] addr_q [DEPTH:1];
  logic [ADDR_W-1:0] addr_d [DEPTH:1];
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic [15:0]       flush_cnt_q, flush_cnt_d;

  logic [DEPTH:0]    early_ld;
  logic [SEL_W-1:0]  rs_k, rt_k;
  logic              rs_haz, rt_haz;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    rs_k = '0;
    rt_k = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_q[k] && wen_q[k]) begin
        if (id_rs_used && id_rs_addr != '0 &&
            addr_q[k] == id_rs_addr)
          rs_k = SEL_W'(k);
        if (id_rt_used && id_rt_addr != '0 &&
            addr_q[k] == id_rt_addr)
          rt_k = SEL_W'(k);
      end
    end
  end

  // Bit k set when stage k holds a load whose data is not ready yet;
  // bit 0 stays clear so "no match" never flags a hazard.
  always_comb begin
    early_ld = '0;
    for (int k = 1; k <= DEPTH; k++)
      early_ld[k] = ld_q[k] && (k <= LOAD_STAGE);
  end

  assign rs_haz = FWD_EN ? early_ld[rs_k] : (rs_k != '0);
  assign rt_haz = FWD_EN ? early_ld[rt_k] : (rt_k != '0);

  assign stall        = id_valid && (rs_haz || rt_haz);
  assign id_ex_bubble = stall;
  assign if_id_flush  = id_valid && id_branch_taken && !stall;
  assign fwd_rs_sel   = (FWD_EN && !rs_haz) ? rs_k : '0;
  assign fwd_rt_sel   = (FWD_EN && !rt_haz) ? rt_k : '0;

  assign stage_valid = vld_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_comb begin
    vld_d       = vld_q;
    wen_d       = wen_q;
    ld_d        = ld_q;
    addr_d      = addr_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cpu_en) begin
      for (int k = DEPTH; k >= 2; k--) begin
        vld_d[k]  = vld_q[k-1];
        wen_d[k]  = wen_q[k-1];
        ld_d[k]   = ld_q[k-1];
        addr_d[k] = addr_q[k-1];
      end
      if (stall || !id_valid) begin
        vld_d[1]  = 1'b0;
        wen_d[1]  = 1'b0;
        ld_d[1]   = 1'b0;
        addr_d[1] = '0;
      end else begin
        vld_d[1]  = 1'b1;
        wen_d[1]  = id_wb_wen;
        ld_d[1]   = id_is_load;
        addr_d[1] = id_wb_addr;
      end
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (if_id_flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!cpu_rst_n) begin
      vld_q       <= '0;
      wen_q       <= '0;
      ld_q        <= '0;
      addr_q      <= '{default: '0};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      wen_q       <= wen_d;
      ld_q        <= ld_d;
      addr_q      <= addr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: forwarding and stall-only instances against a queue-based model.
// Directed load-use/branch/forward sequences, then randomized traffic.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int LS = 1;
  localparam int SW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, v, rsu, rtu, wen, ld, br;
  logic [AW-1:0] rs, rt, wa;

  logic          st  [2];
  logic          bub [2];
  logic          fl  [2];
  logic [SW-1:0] rss [2];
  logic [SW-1:0] rts [2];
  logic [D-1:0]  sv  [2];
  logic [15:0]   sc  [2];
  logic [15:0]   fc  [2];

  pipe_hazard_ctrl #(.ADDR_W(AW), .DEPTH(D), .LOAD_STAGE(LS), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .cpu_rst_n(rst_n), .cpu_en(en), .id_valid(v),
    .id_rs_addr(rs), .id_rt_addr(rt), .id_rs_used(rsu), .id_rt_used(rtu),
    .id_wb_wen(wen), .id_wb_addr(wa), .id_is_load(ld), .id_branch_taken(br),
    .stall(st[0]), .id_ex_bubble(bub[0]), .if_id_flush(fl[0]),
    .fwd_rs_sel(rss[0]), .fwd_rt_sel(rts[0]), .stage_valid(sv[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0]));

  pipe_hazard_ctrl #(.ADDR_W(AW), .DEPTH(D), .LOAD_STAGE(LS), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .cpu_rst_n(rst_n), .cpu_en(en), .id_valid(v),
    .id_rs_addr(rs), .id_rt_addr(rt), .id_rs_used(rsu), .id_rt_used(rtu),
    .id_wb_wen(wen), .id_wb_addr(wa), .id_is_load(ld), .id_branch_taken(br),
    .stall(st[1]), .id_ex_bubble(bub[1]), .if_id_flush(fl[1]),
    .fwd_rs_sel(rss[1]), .fwd_rt_sel(rts[1]), .stage_valid(sv[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  typedef struct {
    bit            v;
    bit            w;
    logic [AW-1:0] a;
    bit            l;
  } ent_t;

  // pipe[m][i] is the instruction i+1 stages past ID; m=0 forwarding, m=1 stall-only.
  ent_t        pipe [2][$];
  int unsigned m_sc [2];
  int unsigned m_fc [2];
  int          checks = 0;
  int          errors = 0;
  bit          chk_on = 0;

  task automatic cmp(input string nm, input int m,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, m, act, exp);
    end
  endtask

  function automatic int young(input int m, input bit used,
                               input logic [AW-1:0] a, output bit isld);
    isld = 0;
    if (!used || a == '0) return 0;
    for (int i = 0; i < pipe[m].size(); i++)
      if (pipe[m][i].v && pipe[m][i].w && pipe[m][i].a == a) begin
        isld = pipe[m][i].l;
        return i + 1;
      end
    return 0;
  endfunction

  function automatic void eval(input int m, output bit est, output bit efl,
                               output int ers, output int ert);
    bit ls, lt, hs, ht;
    int ks, kt;
    ks = young(m, rsu, rs, ls);
    kt = young(m, rtu, rt, lt);
    if (m == 0) begin
      hs = ks != 0 && ls && ks <= LS;
      ht = kt != 0 && lt && kt <= LS;
      ers = hs ? 0 : ks;
      ert = ht ? 0 : kt;
    end else begin
      hs = ks != 0;
      ht = kt != 0;
      ers = 0;
      ert = 0;
    end
    est = v && (hs || ht);
    efl = v && br && !est;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      bit est, efl;
      int ers, ert;
      ent_t e;
      if (!rst_n) begin
        pipe[m].delete();
        m_sc[m] = 0;
        m_fc[m] = 0;
      end else if (en) begin
        eval(m, est, efl, ers, ert);
        if (est && m_sc[m] < 65535) m_sc[m]++;
        if (efl && m_fc[m] < 65535) m_fc[m]++;
        e.v = 0; e.w = 0; e.a = '0; e.l = 0;
        if (!est && v) begin
          e.v = 1; e.w = wen; e.a = wa; e.l = ld;
        end
        pipe[m].push_front(e);
        if (pipe[m].size() > D) void'(pipe[m].pop_back());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on)
      for (int m = 0; m < 2; m++) begin
        bit est, efl;
        int ers, ert;
        logic [D-1:0] esv;
        eval(m, est, efl, ers, ert);
        esv = '0;
        for (int i = 0; i < D; i++)
          if (i < pipe[m].size()) esv[i] = pipe[m][i].v;
        cmp("stall", m, 32'(st[m]), 32'(est));
        cmp("bubble", m, 32'(bub[m]), 32'(est));
        cmp("flush", m, 32'(fl[m]), 32'(efl));
        cmp("rs_sel", m, 32'(rss[m]), ers);
        cmp("rt_sel", m, 32'(rts[m]), ert);
        cmp("stage_valid", m, 32'(sv[m]), 32'(esv));
        cmp("stall_cnt", m, 32'(sc[m]), m_sc[m]);
        cmp("flush_cnt", m, 32'(fc[m]), m_fc[m]);
      end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit vv, input int a_rs, input bit u_rs,
                     input int a_rt, input bit u_rt, input bit w,
                     input int wadr, input bit l, input bit b);
    v = vv; rs = AW'(a_rs); rsu = u_rs; rt = AW'(a_rt); rtu = u_rt;
    wen = w; wa = AW'(wadr); ld = l; br = b;
    #1;
  endtask

  initial begin
    rst_n = 0;
    en = 1;
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0);
    tick();
    tick();
    cmp("rst_sv", 0, 32'(sv[0]), 0);
    cmp("rst_sc", 0, 32'(sc[0]), 0);
    cmp("rst_fc", 0, 32'(fc[0]), 0);
    cmp("rst_stall", 0, 32'(st[0]), 0);
    chk_on = 1;
    rst_n = 1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("idle_stall", 0, 32'(st[0]), 0);
    cmp("idle_flush", 0, 32'(fl[0]), 0);
    cmp("idle_rs", 0, 32'(rss[0]), 0);
    tick();
    drv(1, 1, 1, 0, 0, 1, 2, 0, 0);
    tick();
    drv(1, 2, 1, 2, 1, 1, 3, 0, 0);
    cmp("alu_rs1", 0, 32'(rss[0]), 1);
    cmp("alu_rt1", 0, 32'(rts[0]), 1);
    cmp("alu_st", 0, 32'(st[0]), 0);
    tick();
    drv(1, 2, 1, 0, 0, 1, 4, 0, 0);
    cmp("alu_rs2", 0, 32'(rss[0]), 2);
    tick();
    drv(1, 2, 1, 0, 0, 1, 4, 0, 0);
    cmp("alu_rs3", 0, 32'(rss[0]), 3);
    tick();
    drv(1, 2, 1, 0, 0, 1, 4, 0, 0);
    cmp("alu_rs0", 0, 32'(rss[0]), 0);
    tick();
    drv(1, 1, 1, 0, 0, 1, 2, 1, 0);
    tick();
    drv(1, 2, 1, 1, 1, 1, 4, 0, 0);
    cmp("lu_stall", 0, 32'(st[0]), 1);
    cmp("lu_bub", 0, 32'(bub[0]), 1);
    tick();
    cmp("lu_sv0", 0, 32'(sv[0][0]), 0);
    cmp("lu_clear", 0, 32'(st[0]), 0);
    cmp("lu_rs", 0, 32'(rss[0]), 2);
    cmp("lu_rt", 0, 32'(rts[0]), 0);
    cmp("lu_sc", 0, 32'(sc[0]), 1);
    tick();
    drv(1, 1, 1, 0, 0, 1, 5, 1, 0);
    tick();
    drv(1, 1, 1, 0, 0, 1, 5, 0, 0);
    tick();
    drv(1, 5, 1, 0, 0, 1, 6, 0, 0);
    cmp("yng_rs", 0, 32'(rss[0]), 1);
    cmp("yng_st", 0, 32'(st[0]), 0);
    tick();
    drv(1, 1, 1, 0, 0, 0, 0, 0, 1);
    cmp("br_flush", 0, 32'(fl[0]), 1);
    tick();
    drv(1, 1, 1, 0, 0, 1, 6, 1, 0);
    cmp("br_fc", 0, 32'(fc[0]), 1);
    tick();
    drv(1, 6, 1, 0, 0, 0, 0, 0, 1);
    cmp("brh_stall", 0, 32'(st[0]), 1);
    cmp("brh_flush", 0, 32'(fl[0]), 0);
    tick();
    cmp("brc_stall", 0, 32'(st[0]), 0);
    cmp("brc_flush", 0, 32'(fl[0]), 1);
    tick();
    rst_n = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
    drv(1, 1, 1, 0, 0, 1, 7, 0, 0);
    tick();
    drv(1, 7, 1, 0, 0, 1, 8, 0, 0);
    cmp("nf_fwd_rs", 0, 32'(rss[0]), 1);
    for (int i = 0; i < 3; i++) begin
      cmp("nf_stall", 1, 32'(st[1]), 1);
      cmp("nf_sel", 1, 32'(rss[1]), 0);
      tick();
    end
    cmp("nf_release", 1, 32'(st[1]), 0);
    cmp("nf_sc", 1, 32'(sc[1]), 3);
    tick();
    drv(1, 1, 1, 0, 0, 1, 0, 0, 0);
    tick();
    drv(1, 0, 1, 0, 1, 1, 9, 0, 0);
    cmp("r0_stall", 1, 32'(st[1]), 0);
    cmp("r0_rs", 0, 32'(rss[0]), 0);
    cmp("r0_rt", 0, 32'(rts[0]), 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom % 100) != 0;
      en = ($urandom % 8) != 0;
      drv(($urandom % 5) != 0, $urandom % 4, $urandom % 4 != 0,
          $urandom % 4, $urandom % 2, $urandom % 4 != 0,
          $urandom % 4, $urandom % 3 == 0, $urandom % 6 == 0);
      tick();
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall/flush controller for the N-stage MIPS pipeline. It tracks the destination register of every instruction in flight past ID. It decides per cycle whether the ID instruction must stall, which stage each source operand is forwarded from, and whether IF/ID is squashed by a taken ID-stage branch. It sits beside the datapath and drives the IF/ID and ID/EX register enables and bubble controls. It replaces the fixed 5-stage ad-hoc hazard handling with configurable depth, load latency and forwarding mode.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DEPTH, 3, tracked stages after ID (1=EX … DEPTH=WB); legal 1..7
- LOAD_STAGE, 1, a load's data is unavailable while it sits at stage index ≤ LOAD_STAGE; legal 0..DEPTH-1
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode
- SEL_W (localparam), clog2(DEPTH+1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- cpu_rst_n  in  1  reset, synchronous, active-low
- cpu_en  in  1  global enable; 0 freezes all state
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  ADDR_W  source registers
- id_rs_used, id_rt_used  in  1  source actually read
- id_wb_wen  in  1  ID instruction writes a register
- id_wb_addr  in  ADDR_W  its destination
- id_is_load  in  1  ID instruction is a load
- id_branch_taken  in  1  branch/jump resolved taken in ID
- stall  out  1  hold PC and IF/ID
- id_ex_bubble  out  1  load zeroed controls into ID/EX (equals stall)
- if_id_flush  out  1  squash instruction in IF/ID
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = regfile, k = result of stage k
- stage_valid  out  DEPTH  bit k-1 = stage k holds a real instruction
- stall_cnt  out  16  saturating stall-cycle counter
- flush_cnt  out  16  saturating flush counter

## Operation
- State: DEPTH entries {valid, wen, addr, is_load}, entry 1 = EX.
- Match for a source s: s_used & s≠0 & entry valid & wen & addr==s. Only the youngest (lowest k) match counts. Older matches are ignored.
- FWD_EN=1:
  - Youngest match k with is_load & k≤LOAD_STAGE → hazard.
  - Otherwise fwd_sel = k.
  - No match → fwd_sel = 0.
- FWD_EN=0: any match → hazard. fwd_sel is always 0.
- stall = id_valid & (rs hazard | rt hazard).
- if_id_flush = id_valid & id_branch_taken & ~stall. A stalled branch is not acted on until its operands are clean.
- Shift on cpu_en:
  - entry k+1 ← entry k.
  - entry 1 ← bubble (all zero) if stall or ~id_valid.
  - Otherwise entry 1 ← {1, id_wb_wen, id_wb_addr, id_is_load}.
  - Entry DEPTH is discarded.
- A flushing branch still enters entry 1, because the branch itself completes. Only the fetched successor is squashed, by the datapath.
- Counters increment when cpu_en and the event (stall / if_id_flush) hold. Each holds at 16'hFFFF.

## Timing
- stall, id_ex_bubble, if_id_flush and fwd_* are combinational from ID inputs and registered entries, valid the same cycle.
- stage_valid and the counters are registered.
- Reset (cpu_rst_n=0 at an edge) takes priority over cpu_en. It clears all entries and counters. After reset: stage_valid=0, stall_cnt=0, flush_cnt=0, stall=0, fwd_*=0. if_id_flush is 0 unless ID presents a taken branch.
- Reset mid-stall drops all in-flight entries. The next cycle sees no hazard.
- cpu_en=0: entries and counters hold. Combinational outputs keep tracking inputs.
- Load-use, FWD_EN=1, LOAD_STAGE=L: the consumer stalls (L − k + 1) cycles, where k is the load's stage when the consumer first reaches ID. It then forwards from stage L+1.
- FWD_EN=0, distance-1 dependency: DEPTH stall cycles.

## Test plan
- Reset: cpu_rst_n=0 for 2 cycles with id_valid=1, wen=1 → stage_valid=0, counters 0, stall=0. After release with no input, all outputs remain 0.
- ALU forward (DEPTH=3): addi r2, then add r3,r2,r2 next cycle → fwd_rs_sel=fwd_rt_sel=1, stall=0. A consumer of r2 two instructions later → sel=2. Three later → sel=3. Four later → sel=0.
- Load-use (LOAD_STAGE=1): lw r2, then add r4,r2,r1 → stall=1 for 1 cycle and stage_valid[0]=0 next. Then fwd_rs_sel=2, fwd_rt_sel=0, stall_cnt=1.
- Youngest match: lw r5 followed by addi r5, then consumer of r5 → fwd_rs_sel=1 and no stall; the older load at stage 2 is ignored.
- Branch: taken branch with no hazard → if_id_flush=1, flush_cnt=1. Taken branch whose rs matches a stage-1 load → stall=1, if_id_flush=0 that cycle. After the stall clears → if_id_flush=1.
- FWD_EN=0, DEPTH=3: addi r7, then consumer of r7 → stall for exactly 3 cycles with stall_cnt=3, then stall=0. Reading r0 after an instruction whose destination is r0 → never stalls, sel=0.
